// File: rtl/wb_unit.sv
// wb_unit: RISC-V writeback stage with load extraction, retire pulse and instret counter.
// Optional feature: define WB_MISALIGN_CHK_EN to flag and suppress misaligned loads.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        handshake with the MEM stage
//   in_rd, in_rd_wen         destination register and its write enable
//   in_is_load, in_load_op   load select and funct3
//   in_alu_result            non-load result
//   in_addr_low              load address bits [2:0]
//   mem_rvalid, mem_rdata    memory response (aligned doubleword)
//   flush                    abort a pending load
//   WriteEnable/Addr/Data    register file write port
//   retire, instret          completion pulse and retired-instruction count
//   load_misaligned          misaligned-load pulse (tied low without the macro)
module wb_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_load_op,
    input  logic [63:0] in_alu_result,
    input  logic [2:0]  in_addr_low,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        flush,
    output logic        WriteEnable,
    output logic [4:0]  WriteAddr,
    output logic [63:0] WriteData,
    output logic        retire,
    output logic [63:0] instret,
    output logic        load_misaligned
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t      state;
    logic [4:0]  rdQ;
    logic        rdWenQ;
    logic [2:0]  loadOpQ;
    logic [2:0]  addrLowQ;
    logic [63:0] lane;
    logic [63:0] loadData;
    logic        misaligned;

    assign in_ready = !rst && state == IDLE;

    // Bytes shifted past bit 63 become zero before extension.
    always_comb begin
        lane     = mem_rdata >> {addrLowQ, 3'b000};
        loadData = loadOpQ == 3'b000 ? {{56{lane[7]}}, lane[7:0]} :
                   loadOpQ == 3'b001 ? {{48{lane[15]}}, lane[15:0]} :
                   loadOpQ == 3'b010 ? {{32{lane[31]}}, lane[31:0]} :
                   loadOpQ == 3'b011 ? lane :
                   loadOpQ == 3'b100 ? {56'd0, lane[7:0]} :
                   loadOpQ == 3'b101 ? {48'd0, lane[15:0]} :
                   loadOpQ == 3'b110 ? {32'd0, lane[31:0]} : 64'd0;
`ifdef WB_MISALIGN_CHK_EN
        misaligned = (loadOpQ[1:0] == 2'b01 && addrLowQ[0]) ||
                     (loadOpQ[1:0] == 2'b10 && addrLowQ[1:0] != 2'b00) ||
                     (loadOpQ == 3'b011 && addrLowQ != 3'b000);
`else
        misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rdQ             <= '0;
            rdWenQ          <= 1'b0;
            loadOpQ         <= '0;
            addrLowQ        <= '0;
            WriteEnable     <= 1'b0;
            WriteAddr       <= '0;
            WriteData       <= '0;
            retire          <= 1'b0;
            load_misaligned <= 1'b0;
            instret         <= '0;
        end else begin
            WriteEnable     <= 1'b0;
            retire          <= 1'b0;
            load_misaligned <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && in_is_load) begin
                    rdQ      <= in_rd;
                    rdWenQ   <= in_rd_wen;
                    loadOpQ  <= in_load_op;
                    addrLowQ <= in_addr_low;
                    state    <= WAIT_MEM;
                end else if (in_valid) begin
                    WriteEnable <= in_rd_wen && in_rd != 5'd0;
                    WriteAddr   <= in_rd;
                    WriteData   <= in_alu_result;
                    retire      <= 1'b1;
                    instret     <= instret + 64'd1;
                end
            end else if (flush) begin
                state <= IDLE;
            end else if (mem_rvalid) begin
                WriteEnable     <= rdWenQ && rdQ != 5'd0 && loadOpQ != 3'b111 && !misaligned;
                WriteAddr       <= rdQ;
                WriteData       <= loadData;
                retire          <= 1'b1;
                load_misaligned <= misaligned;
                instret         <= instret + 64'd1;
                state           <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed stimulus with a transaction-level reference model and literal spot checks.
module tb_wb_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_load_op = '0;
    logic [63:0] in_alu_result = '0;
    logic [2:0]  in_addr_low = '0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        flush = 1'b0;
    logic        WriteEnable;
    logic [4:0]  WriteAddr;
    logic [63:0] WriteData;
    logic        retire;
    logic [63:0] instret;
    logic        load_misaligned;

    int checks = 0;
    int errors = 0;

    wb_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
        .in_load_op(in_load_op), .in_alu_result(in_alu_result),
        .in_addr_low(in_addr_low), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .flush(flush), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
        .WriteData(WriteData), .retire(retire), .instret(instret),
        .load_misaligned(load_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: gather the accessed bytes one by one, then widen by load size/signedness.
    function automatic logic [63:0] extract(input logic [2:0] op, input logic [2:0] a, input logic [63:0] d);
        int size = 1 << op[1:0];
        int ai = int'(a);
        logic [63:0] v = '0;
        for (int k = 0; k < size; k++)
            if (ai + k < 8) v[k*8 +: 8] = d[(ai+k)*8 +: 8];
        if (!op[2] && size < 8 && v[size*8-1])
            for (int b = size*8; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic misal(input logic [2:0] op, input logic [2:0] a);
`ifdef WB_MISALIGN_CHK_EN
        int size = 1 << op[1:0];
        return op != 3'b111 && (int'(a) % size) != 0;
`else
        return 1'b0;
`endif
    endfunction

    logic        busy = 1'b0, eWE = 1'b0, eRet = 1'b0, eMis = 1'b0;
    logic [4:0]  eWA = '0, pRd = '0;
    logic [63:0] eWD = '0, eCnt = '0;
    logic        pWen = 1'b0;
    logic [2:0]  pOp = '0, pAddr = '0;

    always @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0; eWE <= 1'b0; eRet <= 1'b0; eMis <= 1'b0; eCnt <= '0;
        end else begin
            eWE <= 1'b0; eRet <= 1'b0; eMis <= 1'b0;
            if (!busy && in_valid && in_is_load) begin
                busy <= 1'b1; pRd <= in_rd; pWen <= in_rd_wen; pOp <= in_load_op; pAddr <= in_addr_low;
            end else if (!busy && in_valid) begin
                eRet <= 1'b1; eWE <= in_rd_wen && in_rd != 0; eWA <= in_rd; eWD <= in_alu_result;
                eCnt <= eCnt + 1;
            end else if (busy && flush) begin
                busy <= 1'b0;
            end else if (busy && mem_rvalid) begin
                busy <= 1'b0; eRet <= 1'b1; eMis <= misal(pOp, pAddr);
                eWE <= pWen && pRd != 0 && pOp != 3'b111 && !misal(pOp, pAddr);
                eWA <= pRd; eWD <= extract(pOp, pAddr, mem_rdata);
                eCnt <= eCnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_we", {63'd0, WriteEnable}, 64'd0);
            chk("rst_retire", {63'd0, retire}, 64'd0);
            chk("rst_wd", WriteData, 64'd0);
            chk("rst_instret", instret, 64'd0);
        end else begin
            chk("ready", {63'd0, in_ready}, {63'd0, !busy});
            chk("we", {63'd0, WriteEnable}, {63'd0, eWE});
            chk("retire", {63'd0, retire}, {63'd0, eRet});
            chk("misaligned", {63'd0, load_misaligned}, {63'd0, eMis});
            chk("instret", instret, eCnt);
            if (eWE) begin
                chk("waddr", {59'd0, WriteAddr}, {59'd0, eWA});
                chk("wdata", WriteData, eWD);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
    endtask

    task automatic send(input logic ld, input logic [2:0] op, input logic [4:0] rd,
                        input logic wen, input logic [63:0] alu, input logic [2:0] a);
        in_valid = 1'b1; in_is_load = ld; in_load_op = op; in_rd = rd;
        in_rd_wen = wen; in_alu_result = alu; in_addr_low = a;
    endtask

    task automatic ld(input logic [2:0] op, input logic [4:0] rd, input logic [2:0] a, input logic [63:0] d);
        send(1'b1, op, rd, 1'b1, 64'd0, a);
        cyc(); idle();
        mem_rvalid = 1'b1; mem_rdata = d;
        cyc(); idle();
    endtask

    initial begin
        rst = 1'b1;
        cyc(); cyc();
        chk("hold_rst_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", {63'd0, in_ready}, 64'd1);
        send(1'b0, 3'b000, 5'd5, 1'b1, 64'h1234, 3'd0);
        cyc(); idle();
        chk("addi_we", {63'd0, WriteEnable}, 64'd1);
        chk("addi_wa", {59'd0, WriteAddr}, 64'd5);
        chk("addi_wd", WriteData, 64'h1234);
        chk("addi_retire", {63'd0, retire}, 64'd1);
        chk("addi_instret", instret, 64'd1);
        cyc();
        chk("pulse_we", {63'd0, WriteEnable}, 64'd0);
        // LB, with an ignored rvalid in the acceptance cycle
        send(1'b1, 3'b000, 5'd7, 1'b1, 64'd0, 3'd3);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
        cyc(); idle();
        chk("lb_wait_ready", {63'd0, in_ready}, 64'd0);
        chk("lb_wait_retire", {63'd0, retire}, 64'd0);
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_8000_0000;
        cyc(); idle();
        chk("lb_we", {63'd0, WriteEnable}, 64'd1);
        chk("lb_wa", {59'd0, WriteAddr}, 64'd7);
        chk("lb_wd", WriteData, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_instret", instret, 64'd2);
        ld(3'b110, 5'd9, 3'd4, 64'hF000_0000_0000_0000);
        chk("lwu_wd", WriteData, 64'h0000_0000_F000_0000);
        ld(3'b010, 5'd9, 3'd4, 64'hF000_0000_0000_0000);
        chk("lw_wd", WriteData, 64'hFFFF_FFFF_F000_0000);
        // flush beats same-cycle rvalid
        send(1'b1, 3'b011, 5'd10, 1'b1, 64'd0, 3'd0);
        cyc(); idle();
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h55;
        cyc(); idle();
        chk("flush_we", {63'd0, WriteEnable}, 64'd0);
        chk("flush_retire", {63'd0, retire}, 64'd0);
        chk("flush_instret", instret, 64'd4);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        send(1'b0, 3'b000, 5'd0, 1'b1, 64'hFF, 3'd0);
        cyc(); idle();
        chk("rd0_we", {63'd0, WriteEnable}, 64'd0);
        chk("rd0_retire", {63'd0, retire}, 64'd1);
        send(1'b0, 3'b000, 5'd3, 1'b1, 64'hABC, 3'd0);
        flush = 1'b1;
        cyc(); idle();
        chk("idle_flush_wd", WriteData, 64'hABC);
        chk("idle_flush_instret", instret, 64'd6);
        ld(3'b001, 5'd4, 3'd2, 64'h0000_0000_8001_0000);
        ld(3'b101, 5'd4, 3'd2, 64'h0000_0000_8001_0000);
        ld(3'b100, 5'd4, 3'd7, 64'hFE00_0000_0000_0000);
        chk("lbu_wd", WriteData, 64'hFE);
        ld(3'b011, 5'd4, 3'd0, 64'h0123_4567_89AB_CDEF);
        ld(3'b111, 5'd4, 3'd0, 64'h1);
        chk("rsvd_we", {63'd0, WriteEnable}, 64'd0);
        chk("rsvd_retire", {63'd0, retire}, 64'd1);
        ld(3'b010, 5'd8, 3'd6, 64'h1234_5678_0000_0000);
        ld(3'b001, 5'd8, 3'd1, 64'h0000_0000_00FF_FF00);
        // new instruction offered while a load is pending is not taken
        send(1'b1, 3'b010, 5'd12, 1'b1, 64'd0, 3'd0);
        cyc();
        send(1'b0, 3'b000, 5'd13, 1'b1, 64'h55, 3'd0);
        cyc(); idle();
        mem_rvalid = 1'b1; mem_rdata = 64'h7;
        cyc(); idle();
        chk("busy_wa", {59'd0, WriteAddr}, 64'd12);
        ld(3'b011, 5'd6, 3'd4, 64'h1234_5678_9ABC_DEF0);
`ifdef WB_MISALIGN_CHK_EN
        chk("ld4_mis", {63'd0, load_misaligned}, 64'd1);
        chk("ld4_we", {63'd0, WriteEnable}, 64'd0);
`else
        chk("ld4_wd", WriteData, 64'h0000_0000_1234_5678);
        chk("ld4_mis", {63'd0, load_misaligned}, 64'd0);
`endif
        chk("ld4_retire", {63'd0, retire}, 64'd1);
        // reset while a load is pending
        send(1'b1, 3'b011, 5'd11, 1'b1, 64'd0, 3'd0);
        cyc(); idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_instret", instret, 64'd0);
        chk("mid_rst_wd", WriteData, 64'd0);
        cyc();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h99;
        cyc(); idle();
        chk("late_rvalid_we", {63'd0, WriteEnable}, 64'd0);
        chk("late_rvalid_retire", {63'd0, retire}, 64'd0);
        send(1'b0, 3'b000, 5'd1, 1'b1, 64'h42, 3'd0);
        cyc(); idle();
        chk("post_rst_instret", instret, 64'd1);
        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
